// File: rtl/mem_stream_reader.sv
// rtl/mem_stream_reader.sv - block RAM read sequencer presenting a valid/ready word stream (optional macro: MEM_STREAM_READER_REVERSE_EN)
module mem_stream_reader #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
`ifdef MEM_STREAM_READER_REVERSE_EN
  input  logic                  reverse,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_wr_en,
  output logic [WIDTH-1:0]      mem_data,
  input  logic [WIDTH-1:0]      mem_q,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   REM_ZERO = '0;

  state_t state_q;
  state_t state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic                  descending_q;
  logic                  start_descending;
  logic [ADDR_WIDTH-1:0] start_addr;

  logic                  inflight_q;
  logic                  inflight_last_q;

  logic [WIDTH-1:0]      fifo_data_q [2];
  logic                  fifo_last_q [2];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;

  logic                  push;
  logic                  pop;
  logic [1:0]            occ;
  logic [1:0]            occ_after_pop;
  logic                  issue;
  logic                  final_issue;
  logic                  accept_start;

  // The write side of the RAM port is never used by this reader.
  assign mem_wr_en = 1'b0;
  assign mem_data  = '0;

  // Transfer direction and first address, fixed at the moment start is taken.
`ifdef MEM_STREAM_READER_REVERSE_EN
  always_comb begin
    start_descending = reverse;
    start_addr       = base_addr;
    if (reverse) begin
      start_addr = base_addr + length[ADDR_WIDTH-1:0] - ADDR_ONE;
    end
  end
`else
  always_comb begin
    start_descending = 1'b0;
    start_addr       = base_addr;
  end
`endif

  // Stream side comes straight from the FIFO head; last is masked when empty.
  always_comb begin
    out_valid = (count_q != 2'd0);
    out_data  = fifo_data_q[rd_ptr_q];
    out_last  = out_valid & fifo_last_q[rd_ptr_q];
  end

  // Flow control: a read is only issued if its word is guaranteed a FIFO slot.
  always_comb begin
    pop           = out_valid & out_ready;
    push          = inflight_q;
    occ           = count_q + {1'b0, inflight_q};
    occ_after_pop = occ - {1'b0, pop};
    issue         = (state_q == READ) && (remaining_q != REM_ZERO) && (occ_after_pop < 2'd2);
    final_issue   = issue && (remaining_q == REM_ONE);
    accept_start  = (state_q == IDLE) && start;
  end

  // Next-state decode plus the status outputs derived from state.
  always_comb begin
    state_next = state_q;
    busy       = (state_q != IDLE);
    done       = (state_q == FINISH);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_next = (length == REM_ZERO) ? FINISH : READ;
        end
      end
      READ: begin
        if (final_issue) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Address and word counters; the address holds after the final read so the
  // RAM port stays quiet on the last issued location.
  always_ff @(posedge clock) begin
    if (rst) begin
      addr_q       <= '0;
      remaining_q  <= '0;
      descending_q <= 1'b0;
    end else if (accept_start) begin
      remaining_q  <= length;
      descending_q <= start_descending;
      if (length != REM_ZERO) begin
        addr_q <= start_addr;
      end
    end else if (issue) begin
      remaining_q <= remaining_q - REM_ONE;
      if (!final_issue) begin
        addr_q <= descending_q ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
      end
    end
  end

  assign mem_address = addr_q;

  // Tracks the one read whose data is still inside the RAM pipeline.
  always_ff @(posedge clock) begin
    if (rst) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= final_issue;
    end
  end

  // Two-entry output FIFO; data arrays are cleared so out_data resets to 0.
  always_ff @(posedge clock) begin
    if (rst) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_q;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb/tb_mem_stream_reader.sv - self-checking bench for mem_stream_reader
module tb_mem_stream_reader;

  logic       clock;
  logic       rst;
  logic       start;
  logic [5:0] base_addr;
  logic [6:0] length;
  logic       busy;
  logic       done;
  logic [5:0] mem_address;
  logic       mem_wr_en;
  logic [7:0] mem_data;
  logic [7:0] mem_q;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  int n_checks;
  int n_fail;

  logic [7:0] ram [64];

  mem_stream_reader #(.WIDTH(8), .ADDR_WIDTH(6)) dut (
    .clock       (clock),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .mem_address (mem_address),
    .mem_wr_en   (mem_wr_en),
    .mem_data    (mem_data),
    .mem_q       (mem_q),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) mem_q <= ram[mem_address];

  function automatic logic [7:0] ram_val(input int a);
    return 8'((a * 37 + 11) & 255);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic       start;
    logic [5:0] base;
    logic [6:0] len;
    logic       busy;
    logic       done;
    logic       valid;
    logic       last;
    logic       chk_data;
    logic [7:0] data;
    logic [5:0] addr;
  } vec_t;

  vec_t vecs [12];

  // One transfer with optional ready-low window, optional ignored start,
  // optional single address probe. Cycle 0 is the cycle start is presented.
  task automatic xfer(input logic [5:0] base, input logic [6:0] len,
                      input int hold_from, input int hold_to,
                      input int ghost_cyc, input int probe_cyc, input logic [5:0] probe_addr);
    int         idx;
    int         done_cyc;
    logic       held;
    logic [7:0] held_data;
    logic       seen_done;
    idx       = 0;
    held      = 1'b0;
    held_data = 8'h00;
    seen_done = 1'b0;
    done_cyc  = -1;
    for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
      if (cyc == 0) begin
        start = 1'b1; base_addr = base; length = len;
      end else if (cyc == ghost_cyc) begin
        start = 1'b1; base_addr = 6'd0; length = 7'd5;
      end else begin
        start = 1'b0;
      end
      out_ready = !(cyc >= hold_from && cyc <= hold_to);
      @(negedge clock);
      if (hold_from < 0 && cyc >= 1 && cyc <= int'(len))
        chk("stream_addr", 32'(mem_address), 32'((int'(base) + cyc - 1) & 63));
      if (cyc == probe_cyc)
        chk("stall_addr", 32'(mem_address), 32'(probe_addr));
      if (held)
        chk("held_data_stable", 32'(out_data), 32'(held_data));
      if (out_valid && out_ready) begin
        chk("word_in_range", 32'(idx < int'(len)), 32'd1);
        chk("stream_data", 32'(out_data), 32'(ram_val((int'(base) + idx) & 63)));
        chk("stream_last", 32'(out_last), 32'(idx == int'(len) - 1));
        idx++;
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
      if (done) begin
        seen_done = 1'b1;
        done_cyc  = cyc;
      end
      next_cycle();
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("done_seen", 32'(seen_done), 32'd1);
    chk("word_count", 32'(idx), 32'(len));
    if (hold_from < 0)
      chk("done_cycle", 32'(done_cyc), 32'(3 + int'(len)));
    @(negedge clock);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
    next_cycle();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    for (int i = 0; i < 64; i++) ram[i] = ram_val(i);
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = 6'd0;
    length    = 7'd0;
    out_ready = 1'b1;

    // base 10 length 4 with ready high, then a zero-length transfer
    vecs[0]  = '{1'b1, 6'd10, 7'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00,       6'd0};
    vecs[1]  = '{1'b0, 6'd0,  7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00,       6'd10};
    vecs[2]  = '{1'b0, 6'd0,  7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00,       6'd11};
    vecs[3]  = '{1'b0, 6'd0,  7'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ram_val(10), 6'd12};
    vecs[4]  = '{1'b0, 6'd0,  7'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ram_val(11), 6'd13};
    vecs[5]  = '{1'b0, 6'd0,  7'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ram_val(12), 6'd13};
    vecs[6]  = '{1'b0, 6'd0,  7'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, ram_val(13), 6'd13};
    vecs[7]  = '{1'b0, 6'd0,  7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00,       6'd13};
    vecs[8]  = '{1'b0, 6'd0,  7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00,       6'd13};
    vecs[9]  = '{1'b1, 6'd20, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00,       6'd13};
    vecs[10] = '{1'b0, 6'd0,  7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00,       6'd13};
    vecs[11] = '{1'b0, 6'd0,  7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00,       6'd13};

    repeat (3) next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      start     = vecs[i].start;
      base_addr = vecs[i].base;
      length    = vecs[i].len;
      out_ready = 1'b1;
      @(negedge clock);
      chk($sformatf("v%0d_busy", i),  32'(busy),        32'(vecs[i].busy));
      chk($sformatf("v%0d_done", i),  32'(done),        32'(vecs[i].done));
      chk($sformatf("v%0d_valid", i), 32'(out_valid),   32'(vecs[i].valid));
      chk($sformatf("v%0d_last", i),  32'(out_last),    32'(vecs[i].last));
      chk($sformatf("v%0d_addr", i),  32'(mem_address), 32'(vecs[i].addr));
      chk($sformatf("v%0d_wr_en", i), 32'(mem_wr_en),   32'd0);
      if (vecs[i].chk_data)
        chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].data));
      next_cycle();
    end

    // ready low cycles 3..9: two reads issued, address parked at 22, start ignored
    xfer(6'd20, 7'd6, 3, 9, 5, 9, 6'd22);

    // address wrap past the top of the RAM: 62,63,0,1
    xfer(6'd62, 7'd4, -1, -1, -1, -1, 6'd0);

    // reset in the middle of an 8-word transfer
    start = 1'b1; base_addr = 6'd30; length = 7'd8; out_ready = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (4) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clock);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_done",  32'(done),        32'd0);
    chk("rst_valid", 32'(out_valid),   32'd0);
    chk("rst_last",  32'(out_last),    32'd0);
    chk("rst_data",  32'(out_data),    32'd0);
    chk("rst_addr",  32'(mem_address), 32'd0);
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("post_rst_no_done",  32'(done),      32'd0);
      chk("post_rst_no_valid", 32'(out_valid), 32'd0);
      next_cycle();
    end
    xfer(6'd40, 7'd3, -1, -1, -1, -1, 6'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
